// File: rtl/multi_issue_dispatcher.sv
// ============================================================================
// multi_issue_dispatcher : in-order prefix dispatch of one held bundle with
//                          a register scoreboard and wrapping transaction IDs
// Rev 1.0
// ============================================================================
`default_nettype none

module multi_issue_dispatcher #(
    parameter int ISSUE_WIDTH = 4,
    parameter int NR_WB_PORTS = 2,
    parameter int ID_WIDTH    = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   bundle_valid_i,
    output logic                                   bundle_ready_o,
    input  logic [ISSUE_WIDTH-1:0]                 bundle_mask_i,
    input  logic [ISSUE_WIDTH-1:0][31:0]           bundle_instr_i,
    input  logic [ISSUE_WIDTH-1:0]                 bundle_wb_i,
    input  logic [ISSUE_WIDTH-1:0][1:0]            bundle_rs_read_i,
    output logic                                   dispatch_valid_o,
    input  logic                                   dispatch_ready_i,
    output logic [ISSUE_WIDTH-1:0]                 dispatch_mask_o,
    output logic [ISSUE_WIDTH-1:0][31:0]           dispatch_instr_o,
    output logic [ISSUE_WIDTH-1:0][ID_WIDTH-1:0]   dispatch_id_o,
    input  logic [NR_WB_PORTS-1:0]                 wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][4:0]            wb_rd_i,
    input  logic                                   flush_i,
    output logic                                   hazard_stall_o
);

    localparam int CNT_W = $clog2(ISSUE_WIDTH + 1);

    logic                                 r_hold_valid;
    logic [ISSUE_WIDTH-1:0]               r_rem_mask;
    logic [ISSUE_WIDTH-1:0][31:0]         r_instr;
    logic [ISSUE_WIDTH-1:0]               r_wb;
    logic [ISSUE_WIDTH-1:0][1:0]          r_rs_read;
    logic [31:0]                          r_sb;
    logic [ID_WIDTH-1:0]                  r_id_cnt;

    logic [ISSUE_WIDTH-1:0]               w_mask;
    logic [ISSUE_WIDTH-1:0][ID_WIDTH-1:0] w_ids;
    logic [CNT_W-1:0]                     w_pop;
    logic [ID_WIDTH-1:0]                  w_run;
    logic                                 w_blocked;
    logic                                 w_haz;
    logic [31:0]                          w_inflight;
    logic [4:0]                           w_rd;
    logic [4:0]                           w_rs1;
    logic [4:0]                           w_rs2;
    logic [31:0]                          w_sb_next;
    logic                                 w_fire;
    logic                                 w_accept;
    logic [ISSUE_WIDTH-1:0]               w_rem_after;

    // Walk slots in order; w_inflight holds rds offered earlier this cycle.
    always_comb begin
        w_mask     = '0;
        w_ids      = '0;
        w_pop      = '0;
        w_run      = r_id_cnt;
        w_blocked  = 1'b0;
        w_haz      = 1'b0;
        w_inflight = '0;
        w_rd       = '0;
        w_rs1      = '0;
        w_rs2      = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            w_rd     = r_instr[k][11:7];
            w_rs1    = r_instr[k][19:15];
            w_rs2    = r_instr[k][24:20];
            w_haz    = 1'b0;
            w_ids[k] = w_run;
            if (r_rs_read[k][0] && (r_sb[w_rs1] || w_inflight[w_rs1])) w_haz = 1'b1;
            if (r_rs_read[k][1] && (r_sb[w_rs2] || w_inflight[w_rs2])) w_haz = 1'b1;
            if (r_wb[k] && (r_sb[w_rd] || w_inflight[w_rd]))           w_haz = 1'b1;
            if (r_hold_valid && r_rem_mask[k] && !w_blocked) begin
                if (w_haz) begin
                    w_blocked = 1'b1;
                end else begin
                    w_mask[k] = 1'b1;
                    w_run     = w_run + ID_WIDTH'(1);
                    w_pop     = w_pop + CNT_W'(1);
                    if (r_wb[k] && (w_rd != 5'd0)) w_inflight[w_rd] = 1'b1;
                end
            end
        end
    end

    assign dispatch_mask_o  = w_mask;
    assign dispatch_valid_o = r_hold_valid & (|w_mask);
    assign dispatch_instr_o = r_instr;
    assign dispatch_id_o    = w_ids;
    assign hazard_stall_o   = r_hold_valid & ~dispatch_valid_o;

    // A flush suppresses both the dispatch handshake and bundle acceptance.
    assign w_fire         = dispatch_valid_o & dispatch_ready_i & ~flush_i;
    assign w_rem_after    = r_rem_mask & ~w_mask;
    assign bundle_ready_o = ~flush_i & (~r_hold_valid | (w_fire & (w_rem_after == '0)));
    assign w_accept       = bundle_valid_i & bundle_ready_o;

    // Clears first, then dispatch sets, so a set wins over a same-cycle clear.
    always_comb begin
        w_sb_next = r_sb;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (wb_valid_i[p]) w_sb_next[wb_rd_i[p]] = 1'b0;
        end
        if (w_fire) begin
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                if (w_mask[k] && r_wb[k]) w_sb_next[r_instr[k][11:7]] = 1'b1;
            end
        end
        w_sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold_valid <= 1'b0;
            r_rem_mask   <= '0;
            r_instr      <= '0;
            r_wb         <= '0;
            r_rs_read    <= '0;
            r_sb         <= '0;
            r_id_cnt     <= '0;
        end else begin
            r_sb <= w_sb_next;
            if (w_fire) r_id_cnt <= r_id_cnt + ID_WIDTH'(w_pop);
            if (flush_i) begin
                r_hold_valid <= 1'b0;
                r_rem_mask   <= '0;
            end else if (w_accept) begin
                r_hold_valid <= |bundle_mask_i;
                r_rem_mask   <= bundle_mask_i;
                r_instr      <= bundle_instr_i;
                r_wb         <= bundle_wb_i;
                r_rs_read    <= bundle_rs_read_i;
            end else if (w_fire) begin
                r_rem_mask <= w_rem_after;
                if (w_rem_after == '0) r_hold_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/multi_issue_dispatcher.md
# multi_issue_dispatcher

Parametrised in-order dispatch stage that sits between the multi-issue decoder and the execution lanes. It holds one decoded bundle of up to ISSUE_WIDTH instructions. Each cycle it dispatches the longest hazard-free in-order prefix of the remaining slots, instead of stalling the whole bundle on any intra-bundle dependency. A register scoreboard tracks in-flight destination registers across cycles until lane writeback completes. Each dispatched instruction receives a wrapping transaction ID.

## Interface
Parameters:
- ISSUE_WIDTH, 4: slots per bundle; legal range 2..8.
- NR_WB_PORTS, 2: writeback-completion ports.
- ID_WIDTH, 4: transaction ID width; IDs wrap modulo 2^ID_WIDTH.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- bundle_valid_i  in  1  upstream bundle valid.
- bundle_ready_o  out  1  bundle accepted when bundle_valid_i & bundle_ready_o.
- bundle_mask_i  in  ISSUE_WIDTH  valid slots.
- bundle_instr_i  in  ISSUE_WIDTH×32  raw instructions; rd=[11:7], rs1=[19:15], rs2=[24:20].
- bundle_wb_i  in  ISSUE_WIDTH  slot writes rd.
- bundle_rs_read_i  in  ISSUE_WIDTH×2  bit0 = reads rs1, bit1 = reads rs2.
- dispatch_valid_o  out  1  at least one slot offered this cycle.
- dispatch_ready_i  in  1  lanes accept the whole offered mask.
- dispatch_mask_o  out  ISSUE_WIDTH  slots offered this cycle.
- dispatch_instr_o  out  ISSUE_WIDTH×32  held instructions, passed through unchanged.
- dispatch_id_o  out  ISSUE_WIDTH×ID_WIDTH  per-slot ID; valid only where the mask is set.
- wb_valid_i  in  NR_WB_PORTS  writeback completion.
- wb_rd_i  in  NR_WB_PORTS×5  completed destination register.
- flush_i  in  1  discard the held bundle.
- hazard_stall_o  out  1  bundle held but nothing dispatchable.

## Operation
Hold register:
- Contents: hold_valid, rem_mask, instr, wb and rs_read.
- On accept, rem_mask is loaded from bundle_mask_i.
- A bundle with mask 0 is accepted and dropped; hold_valid stays 0.
- bundle_ready_o = ~hold_valid | (fire & (rem_mask & ~dispatch_mask_o) == 0), where fire = dispatch_valid_o & dispatch_ready_i.
- This allows back-to-back bundles with no bubble.

Slot eligibility, evaluated in index order over set bits of rem_mask:
- Scoreboard hazard: the slot reads rs1 or rs2, and that register's scoreboard bit is set (RAW).
- Scoreboard hazard: the slot has wb set and the rd scoreboard bit is set (WAW).
- Intra-cycle hazard: an earlier slot offered this cycle writes rd≠0, and this slot reads that register (RAW) or writes the same rd (WAW).
- x0 is never a hazard source.
- Masked-off slots are skipped and do not block.
- The first remaining slot with any hazard stops the prefix; no later slot is offered (strict in-order).

Outputs and fire:
- dispatch_mask_o is the eligible prefix; dispatch_valid_o = hold_valid & |dispatch_mask_o.
- hazard_stall_o = hold_valid & ~dispatch_valid_o.
- dispatch_id_o[k] = id_cnt + (number of offered slots below k), truncated to ID_WIDTH.
- On fire:
  - rem_mask clears the offered bits.
  - id_cnt advances by popcount(dispatch_mask_o).
  - The scoreboard sets the rd bit of every offered slot with wb=1 and rd≠0.
  - hold_valid clears when rem_mask becomes 0, unless a new bundle is accepted in the same cycle.
- No fire (valid & ~ready): the offer stays stable, with no state change other than writeback clears.

Scoreboard:
- 32 bits; bit 0 is never set.
- wb_valid_i[p] clears bit wb_rd_i[p].
- A set on dispatch and a clear for the same register in the same cycle: set wins.
- There is no bypass. A clear is visible to eligibility from the next cycle.

flush_i:
- Clears hold_valid and rem_mask.
- Has priority over dispatch and accept: no fire, and bundle_ready_o=0 during the flush cycle.
- The scoreboard and id_cnt are preserved, because in-flight operations still write back.

## Timing
- Reset values: hold_valid=0, rem_mask=0, scoreboard=0, id_cnt=0.
- Outputs after reset: bundle_ready_o=1, dispatch_valid_o=0, dispatch_mask_o=0, hazard_stall_o=0.
- Latency: a bundle accepted at edge N can be offered in cycle N+1.
- dispatch_* are combinational from the hold register and scoreboard.
- bundle_ready_o is combinational from dispatch_ready_i.
- Dependency across writeback: a slot blocked on register r dispatches no earlier than the cycle after wb_valid_i clears r.
- id_cnt wraps modulo 2^ID_WIDTH with no stall. ID uniqueness among in-flight operations is the consumer's responsibility.

## Test plan
- Independent bundle: mask 1111, rd x1..x4, all rs = x10. One cycle with mask 1111, IDs 0,1,2,3, bundle_ready_o=1 in the same cycle, scoreboard = x1..x4.
- Intra-bundle RAW: slot0 writes x5, slot2 reads rs1=x5, mask 1111.
  - Cycle 1: mask 0011, IDs 0,1.
  - Then hazard_stall_o=1 until wb_valid_i[0], wb_rd_i=5.
  - The following cycle: mask 1100, IDs 2,3.
- WAW: slot1 rd=x7 while the scoreboard already holds x7. Slot0 is offered alone, and slot1 stalls until x7 is cleared.
- Backpressure: dispatch_ready_i=0 for 3 cycles. The offer, IDs and scoreboard are unchanged; the bundle fires when ready rises.
- Flush with rem_mask=1100 and a pending hazard: hold is cleared the next cycle, scoreboard bits remain, and the next bundle's IDs continue from id_cnt.
- Simultaneous events and wrap:
  - Dispatch setting x3 while wb clears x3 in the same cycle leaves x3 set.
  - With ID_WIDTH=4, after 14 dispatched slots a 4-slot bundle gets IDs 14,15,0,1.
